// File: rtl/dma_axi_pkg.sv
// Shared types and helpers for the DMA AXI slave memory.
//   RESP_OKAY / RESP_SLVERR : AXI response codes
//   wr_state_e / rd_state_e : write and read FSM states
//   addr_next()             : INCR burst address step (addr + 2^size)
package dma_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WIdle,
    WData,
    WBwait,
    WResp
  } wr_state_e;

  typedef enum logic [1:0] {
    RIdle,
    RLat,
    RData
  } rd_state_e;

  // Computed at 64 bits; callers truncate to their address width so the step wraps.
  function automatic logic [63:0] addr_next(input logic [63:0] addr, input logic [2:0] size);
    return addr + (64'd1 << size);
  endfunction

endpackage

// File: rtl/dma_axi_mem_slave_if.sv
// AXI3-style 64-bit channel bundle (AW/W/B/AR/R) between the DMA master and the slave memory.
//   master modport : drives requests, write data and response readies
//   slave  modport : drives readies, write response and read data
interface dma_axi_mem_slave_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ID_W   = 1
) ();

  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [3:0]        awlen;
  logic [2:0]        awsize;
  logic              awvalid;
  logic              awready;

  logic [ID_W-1:0]   wid;
  logic [63:0]       wdata;
  logic [7:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arlen;
  logic [2:0]        arsize;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [63:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output awid, awaddr, awlen, awsize, awvalid, wid, wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awvalid, wid, wdata, wstrb, wlast, wvalid, bready,
    input  arid, araddr, arlen, arsize, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/dma_axi_mem_ram.sv
// 64-bit synchronous RAM, one byte-enable write port and one registered read port.
//   we_i/waddr_i/wdata_i/wstrb_i : write port, enabled bytes written on the clock edge
//   re_i/raddr_i/rdata_o         : read port, rdata_o loads on re_i and holds otherwise
// A read and write of the same word on one edge returns the old contents.
module dma_axi_mem_ram #(
  parameter int unsigned AddrW = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [63:0]      wdata_i,
  input  logic [7:0]       wstrb_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [63:0]      rdata_o
);

  logic [63:0] mem_q [2**AddrW];
  logic [63:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 8; b++) begin
      if (we_i && wstrb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dma_axi_mem_slave.sv
// AXI3-style 64-bit slave memory (INCR bursts, one outstanding write and one outstanding read).
//   clk, reset : clock and asynchronous active-low reset
//   axi        : slave side of the AW/W/B/AR/R bundle
//   err_cnt    : saturating count of errored write bursts and errored read beats
module dma_axi_mem_slave
  import dma_axi_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned ID_W           = 1,
  parameter int unsigned MEM_WORDS_LOG2 = 10,
  parameter int unsigned R_LATENCY      = 2,
  parameter int unsigned B_LATENCY      = 1
) (
  input  logic                clk,
  input  logic                reset,
  dma_axi_mem_slave_if.slave  axi,
  output logic [15:0]         err_cnt
);

  localparam logic [7:0] RLatInit = (R_LATENCY > 0) ? 8'(R_LATENCY - 1) : 8'd0;
  localparam logic [7:0] BLatInit = (B_LATENCY > 0) ? 8'(B_LATENCY - 1) : 8'd0;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a >> (MEM_WORDS_LOG2 + 3)) == '0;
  endfunction

  wr_state_e         w_state_q, w_state_d;
  logic [ID_W-1:0]   aw_id_q, aw_id_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d, w_addr_nxt;
  logic [3:0]        aw_len_q, aw_len_d, w_cnt_q, w_cnt_d;
  logic [2:0]        aw_size_q, aw_size_d;
  logic              w_err_q, w_err_d, w_beat_err, b_inc;
  logic [7:0]        b_lat_q, b_lat_d;

  rd_state_e         r_state_q, r_state_d;
  logic [ID_W-1:0]   ar_id_q, ar_id_d;
  logic [ADDR_W-1:0] ar_addr_q, ar_addr_d, r_addr_nxt, ld_addr;
  logic [3:0]        ar_len_q, ar_len_d, r_cnt_q, r_cnt_d;
  logic [2:0]        ar_size_q, ar_size_d, ld_size;
  logic [7:0]        r_lat_q, r_lat_d;
  logic              r_last_q, r_last_d, r_err_q, r_err_d, ld_en, ld_last, r_inc;

  // Holds the readies low during reset so they rise on the first edge after release.
  logic              live_q;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic              ram_we;
  logic [63:0]       ram_rdata;

  assign w_addr_nxt = ADDR_W'(addr_next(64'(aw_addr_q), aw_size_q));
  assign r_addr_nxt = ADDR_W'(addr_next(64'(ar_addr_q), ar_size_q));
  assign w_beat_err = (axi.wlast != (w_cnt_q == aw_len_q)) || (axi.wid != aw_id_q) ||
                      (aw_size_q > 3'd3) || !in_range(aw_addr_q);

  // Write FSM
  always_comb begin
    w_state_d   = w_state_q;
    aw_id_d     = aw_id_q;
    aw_addr_d   = aw_addr_q;
    aw_len_d    = aw_len_q;
    aw_size_d   = aw_size_q;
    w_cnt_d     = w_cnt_q;
    w_err_d     = w_err_q;
    b_lat_d     = b_lat_q;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    ram_we      = 1'b0;
    b_inc       = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        axi.awready = live_q;
        if (axi.awvalid && live_q) begin
          aw_id_d   = axi.awid;
          aw_addr_d = axi.awaddr;
          aw_len_d  = axi.awlen;
          aw_size_d = axi.awsize;
          w_cnt_d   = 4'd0;
          w_err_d   = 1'b0;
          w_state_d = WData;
        end
      end
      WData: begin
        axi.wready = 1'b1;
        if (axi.wvalid) begin
          ram_we    = !w_beat_err;
          w_err_d   = w_err_q | w_beat_err;
          aw_addr_d = w_addr_nxt;
          w_cnt_d   = w_cnt_q + 4'd1;
          // The beat count, not wlast, ends the burst.
          if (w_cnt_q == aw_len_q) begin
            w_state_d = (B_LATENCY == 0) ? WResp : WBwait;
            b_lat_d   = BLatInit;
          end
        end
      end
      WBwait: begin
        if (b_lat_q == 8'd0) w_state_d = WResp;
        else                 b_lat_d   = b_lat_q - 8'd1;
      end
      WResp: begin
        axi.bvalid = 1'b1;
        if (axi.bready) begin
          b_inc     = w_err_q;
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  // Read FSM; ld_en loads the RAM output register with the beat about to be presented.
  always_comb begin
    r_state_d   = r_state_q;
    ar_id_d     = ar_id_q;
    ar_addr_d   = ar_addr_q;
    ar_len_d    = ar_len_q;
    ar_size_d   = ar_size_q;
    r_cnt_d     = r_cnt_q;
    r_lat_d     = r_lat_q;
    r_last_d    = r_last_q;
    r_err_d     = r_err_q;
    ld_en       = 1'b0;
    ld_addr     = ar_addr_q;
    ld_size     = ar_size_q;
    ld_last     = 1'b0;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    r_inc       = 1'b0;
    unique case (r_state_q)
      RIdle: begin
        axi.arready = live_q;
        if (axi.arvalid && live_q) begin
          ar_id_d   = axi.arid;
          ar_addr_d = axi.araddr;
          ar_len_d  = axi.arlen;
          ar_size_d = axi.arsize;
          r_cnt_d   = 4'd0;
          if (R_LATENCY == 0) begin
            r_state_d = RData;
            ld_en     = 1'b1;
            ld_addr   = axi.araddr;
            ld_size   = axi.arsize;
            ld_last   = (axi.arlen == 4'd0);
          end else begin
            r_state_d = RLat;
            r_lat_d   = RLatInit;
          end
        end
      end
      RLat: begin
        if (r_lat_q == 8'd0) begin
          r_state_d = RData;
          ld_en     = 1'b1;
          ld_last   = (ar_len_q == 4'd0);
        end else begin
          r_lat_d = r_lat_q - 8'd1;
        end
      end
      RData: begin
        axi.rvalid = 1'b1;
        if (axi.rready) begin
          r_inc = r_err_q;
          if (r_last_q) begin
            r_state_d = RIdle;
          end else begin
            ld_en     = 1'b1;
            ld_addr   = r_addr_nxt;
            ar_addr_d = r_addr_nxt;
            r_cnt_d   = r_cnt_q + 4'd1;
            ld_last   = ((r_cnt_q + 4'd1) == ar_len_q);
          end
        end
      end
      default: r_state_d = RIdle;
    endcase
    if (ld_en) begin
      r_last_d = ld_last;
      r_err_d  = (ld_size > 3'd3) || !in_range(ld_addr);
    end
  end

  always_comb begin
    logic [16:0] sum;
    sum       = {1'b0, err_cnt_q} + {16'd0, b_inc} + {16'd0, r_inc};
    err_cnt_d = sum[16] ? 16'hFFFF : sum[15:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live_q    <= 1'b0;
      w_state_q <= WIdle;
      aw_id_q   <= '0;
      aw_addr_q <= '0;
      aw_len_q  <= '0;
      aw_size_q <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
      b_lat_q   <= '0;
      r_state_q <= RIdle;
      ar_id_q   <= '0;
      ar_addr_q <= '0;
      ar_len_q  <= '0;
      ar_size_q <= '0;
      r_cnt_q   <= '0;
      r_lat_q   <= '0;
      r_last_q  <= 1'b0;
      r_err_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      live_q    <= 1'b1;
      w_state_q <= w_state_d;
      aw_id_q   <= aw_id_d;
      aw_addr_q <= aw_addr_d;
      aw_len_q  <= aw_len_d;
      aw_size_q <= aw_size_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
      b_lat_q   <= b_lat_d;
      r_state_q <= r_state_d;
      ar_id_q   <= ar_id_d;
      ar_addr_q <= ar_addr_d;
      ar_len_q  <= ar_len_d;
      ar_size_q <= ar_size_d;
      r_cnt_q   <= r_cnt_d;
      r_lat_q   <= r_lat_d;
      r_last_q  <= r_last_d;
      r_err_q   <= r_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  dma_axi_mem_ram #(
    .AddrW (MEM_WORDS_LOG2)
  ) u_ram (
    .clk_i   (clk),
    .rst_ni  (reset),
    .we_i    (ram_we),
    .waddr_i (aw_addr_q[MEM_WORDS_LOG2+2:3]),
    .wdata_i (axi.wdata),
    .wstrb_i (axi.wstrb),
    .re_i    (ld_en),
    .raddr_i (ld_addr[MEM_WORDS_LOG2+2:3]),
    .rdata_o (ram_rdata)
  );

  assign axi.bid   = aw_id_q;
  assign axi.bresp = w_err_q ? RESP_SLVERR : RESP_OKAY;
  assign axi.rid   = ar_id_q;
  assign axi.rdata = r_err_q ? 64'd0 : ram_rdata;
  assign axi.rresp = r_err_q ? RESP_SLVERR : RESP_OKAY;
  assign axi.rlast = r_last_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_dma_axi_mem_slave.sv
// Directed bench for dma_axi_mem_slave: writes, bursts, strobes, range and protocol errors, reset.
module tb_dma_axi_mem_slave;
  import dma_axi_pkg::*;

  localparam int unsigned AddrW = 32;
  localparam int unsigned IdW   = 1;
  localparam int unsigned RLat  = 2;
  localparam int unsigned BLat  = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] err_cnt;
  int          n_tests = 0;
  int          n_fail = 0;

  logic [63:0] wbuf [16];
  logic [63:0] rbuf [16];
  logic [1:0]  rresp_buf [16];
  logic        rlast_buf [16];
  int          r_lat;
  int          b_wait;

  always #5 clk = ~clk;

  dma_axi_mem_slave_if #(.ADDR_W(AddrW), .ID_W(IdW)) axi ();

  dma_axi_mem_slave #(
    .ADDR_W         (AddrW),
    .ID_W           (IdW),
    .MEM_WORDS_LOG2 (10),
    .R_LATENCY      (RLat),
    .B_LATENCY      (BLat)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .axi     (axi),
    .err_cnt (err_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pat(input logic [15:0] seed, input int i);
    return {16'hC0DE, seed, 24'h0, 8'(i)};
  endfunction

  task automatic send_aw(input logic [31:0] addr, input logic [3:0] len, input logic [IdW-1:0] id);
    int n;
    axi.awaddr  = addr;
    axi.awlen   = len;
    axi.awsize  = 3'd3;
    axi.awid    = id;
    axi.awvalid = 1'b1;
    n = 0;
    while (!axi.awready && n < 50) begin tick(); n++; end
    check("aw_ready", 64'(axi.awready), 64'd1);
    tick();
    axi.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [3:0] len, input logic [IdW-1:0] wid, input int early_last,
                        input logic [7:0] strb);
    int n;
    for (int i = 0; i <= int'(len); i++) begin
      axi.wdata  = wbuf[i];
      axi.wstrb  = strb;
      axi.wid    = wid;
      axi.wlast  = (i == int'(len)) || (i == early_last);
      axi.wvalid = 1'b1;
      n = 0;
      while (!axi.wready && n < 50) begin tick(); n++; end
      check("w_ready", 64'(axi.wready), 64'd1);
      tick();
    end
    axi.wvalid = 1'b0;
    axi.wlast  = 1'b0;
  endtask

  task automatic write_burst(input string tag, input logic [31:0] addr, input logic [3:0] len,
                             input logic [IdW-1:0] id, input logic [IdW-1:0] wid,
                             input int early_last, input logic [7:0] strb, input int hold,
                             input logic [1:0] exp_resp);
    send_aw(addr, len, id);
    send_w(len, wid, early_last, strb);
    b_wait = 0;
    while (!axi.bvalid && b_wait < 50) begin tick(); b_wait++; end
    check({tag, "_bvalid"}, 64'(axi.bvalid), 64'd1);
    for (int d = 0; d < hold; d++) begin
      tick();
      check({tag, "_bhold_valid"}, 64'(axi.bvalid), 64'd1);
      check({tag, "_bhold_id"}, 64'(axi.bid), 64'(id));
      check({tag, "_bhold_resp"}, 64'(axi.bresp), 64'(exp_resp));
    end
    axi.bready = 1'b1;
    check({tag, "_bresp"}, 64'(axi.bresp), 64'(exp_resp));
    check({tag, "_bid"}, 64'(axi.bid), 64'(id));
    tick();
    axi.bready = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] addr, input logic [3:0] len, input logic [IdW-1:0] id);
    int n;
    axi.araddr  = addr;
    axi.arlen   = len;
    axi.arsize  = 3'd3;
    axi.arid    = id;
    axi.arvalid = 1'b1;
    n = 0;
    while (!axi.arready && n < 50) begin tick(); n++; end
    check("ar_ready", 64'(axi.arready), 64'd1);
    tick();
    axi.arvalid = 1'b0;
  endtask

  task automatic read_burst(input string tag, input logic [31:0] addr, input logic [3:0] len,
                            input logic [IdW-1:0] id, input bit toggle);
    logic [63:0] snap;
    send_ar(addr, len, id);
    r_lat = 0;
    while (!axi.rvalid && r_lat < 50) begin tick(); r_lat++; end
    for (int i = 0; i <= int'(len); i++) begin
      if (toggle && (i % 2 == 1)) begin
        axi.rready = 1'b0;
        snap = axi.rdata;
        tick();
        check({tag, "_stall_valid"}, 64'(axi.rvalid), 64'd1);
        check({tag, "_stall_data"}, axi.rdata, snap);
      end
      axi.rready   = 1'b1;
      check({tag, "_rvalid"}, 64'(axi.rvalid), 64'd1);
      check({tag, "_rid"}, 64'(axi.rid), 64'(id));
      rbuf[i]      = axi.rdata;
      rresp_buf[i] = axi.rresp;
      rlast_buf[i] = axi.rlast;
      tick();
    end
    axi.rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awvalid = 1'b0;
    axi.wid = '0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
    axi.bready = 1'b0;
    axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arvalid = 1'b0;
    axi.rready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_awready", 64'(axi.awready), 64'd0);
    check("rst_arready", 64'(axi.arready), 64'd0);
    check("rst_bvalid", 64'(axi.bvalid), 64'd0);
    check("rst_rvalid", 64'(axi.rvalid), 64'd0);
    check("rst_rdata", axi.rdata, 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    reset = 1'b1;
    tick();
    check("rel_awready", 64'(axi.awready), 64'd1);
    check("rel_arready", 64'(axi.arready), 64'd1);

    // Single beat write and read-back with latency checks
    wbuf[0] = 64'hDEADBEEF_CAFEF00D;
    write_burst("w10", 32'h10, 4'd0, 1'b0, 1'b0, -1, 8'hFF, 0, RESP_OKAY);
    check("w10_blat", 64'(b_wait), 64'(BLat));
    read_burst("r10", 32'h10, 4'd0, 1'b0, 1'b0);
    check("r10_lat", 64'(r_lat), 64'(RLat));
    check("r10_data", rbuf[0], 64'hDEADBEEF_CAFEF00D);
    check("r10_resp", 64'(rresp_buf[0]), 64'(RESP_OKAY));
    check("r10_last", 64'(rlast_buf[0]), 64'd1);

    // 16-beat burst, B held off, read back with rready toggling
    for (int i = 0; i < 16; i++) wbuf[i] = pat(16'h0100, i);
    write_burst("w100", 32'h100, 4'd15, 1'b1, 1'b1, -1, 8'hFF, 5, RESP_OKAY);
    check("w100_bdone", 64'(axi.bvalid), 64'd0);
    read_burst("r100", 32'h100, 4'd15, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      check("r100_data", rbuf[i], pat(16'h0100, i));
      check("r100_last", 64'(rlast_buf[i]), (i == 15) ? 64'd1 : 64'd0);
    end

    // Partial strobe
    wbuf[0] = 64'hFFFFFFFF_FFFFFFFF;
    write_burst("w200a", 32'h200, 4'd0, 1'b0, 1'b0, -1, 8'hFF, 0, RESP_OKAY);
    wbuf[0] = 64'h11223344_55667788;
    write_burst("w200b", 32'h200, 4'd0, 1'b0, 1'b0, -1, 8'h0F, 0, RESP_OKAY);
    read_burst("r200", 32'h200, 4'd0, 1'b0, 1'b0);
    check("r200_data", rbuf[0], 64'hFFFFFFFF_55667788);
    check("err_after_ok", 64'(err_cnt), 64'd0);

    // Out of range: 0x2000 aliases word 0 in the low bits, which must stay untouched
    wbuf[0] = 64'h01234567_89ABCDEF;
    write_burst("w0", 32'h0, 4'd0, 1'b0, 1'b0, -1, 8'hFF, 0, RESP_OKAY);
    wbuf[0] = 64'hBAD0BAD0_BAD0BAD0;
    write_burst("woor", 32'h2000, 4'd0, 1'b0, 1'b0, -1, 8'hFF, 0, RESP_SLVERR);
    read_burst("roor", 32'h2000, 4'd0, 1'b0, 1'b0);
    check("roor_resp", 64'(rresp_buf[0]), 64'(RESP_SLVERR));
    check("roor_data", rbuf[0], 64'd0);
    check("oor_err_cnt", 64'(err_cnt), 64'd2);
    read_burst("r0", 32'h0, 4'd0, 1'b0, 1'b0);
    check("r0_unchanged", rbuf[0], 64'h01234567_89ABCDEF);
    check("r0_resp", 64'(rresp_buf[0]), 64'(RESP_OKAY));

    // Protocol errors: early wlast, then wid mismatch, then a clean burst
    for (int i = 0; i < 4; i++) wbuf[i] = pat(16'h0300, i);
    write_burst("wlast_err", 32'h300, 4'd3, 1'b0, 1'b0, 1, 8'hFF, 0, RESP_SLVERR);
    check("wlast_err_cnt", 64'(err_cnt), 64'd3);
    write_burst("wid_err", 32'h400, 4'd3, 1'b0, 1'b1, -1, 8'hFF, 0, RESP_SLVERR);
    check("wid_err_cnt", 64'(err_cnt), 64'd4);
    wbuf[0] = 64'h55AA55AA_AA55AA55;
    write_burst("w500", 32'h500, 4'd0, 1'b1, 1'b1, -1, 8'hFF, 0, RESP_OKAY);
    check("w500_err_cnt", 64'(err_cnt), 64'd4);

    // Reset in the middle of an 8-beat read
    for (int i = 0; i < 8; i++) wbuf[i] = pat(16'h0600, i);
    write_burst("w600", 32'h600, 4'd7, 1'b0, 1'b0, -1, 8'hFF, 0, RESP_OKAY);
    send_ar(32'h600, 4'd7, 1'b0);
    n = 0;
    while (!axi.rvalid && n < 50) begin tick(); n++; end
    axi.rready = 1'b1;
    tick();
    tick();
    axi.rready = 1'b0;
    check("rstr_pre_rvalid", 64'(axi.rvalid), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("rstr_rvalid", 64'(axi.rvalid), 64'd0);
    check("rstr_arready", 64'(axi.arready), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    check("rstr_rel_arready", 64'(axi.arready), 64'd1);

    // Reset while a write response is pending
    wbuf[0] = pat(16'h0700, 0);
    send_aw(32'h700, 4'd0, 1'b0);
    send_w(4'd0, 1'b0, -1, 8'hFF);
    n = 0;
    while (!axi.bvalid && n < 50) begin tick(); n++; end
    check("rstw_pre_bvalid", 64'(axi.bvalid), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("rstw_bvalid", 64'(axi.bvalid), 64'd0);
    check("rstw_awready", 64'(axi.awready), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    check("rstw_rel_awready", 64'(axi.awready), 64'd1);
    check("rstw_err_cnt", 64'(err_cnt), 64'd0);

    // Memory survives reset
    read_burst("rpost10", 32'h10, 4'd0, 1'b0, 1'b0);
    check("rpost10_data", rbuf[0], 64'hDEADBEEF_CAFEF00D);
    read_burst("rpost600", 32'h600, 4'd7, 1'b1, 1'b0);
    check("rpost600_lat", 64'(r_lat), 64'(RLat));
    for (int i = 0; i < 8; i++) begin
      check("rpost600_data", rbuf[i], pat(16'h0600, i));
      check("rpost600_resp", 64'(rresp_buf[i]), 64'(RESP_OKAY));
    end
    check("final_err_cnt", 64'(err_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
